alu_result_sel_pipe: RTL and testbench
======================================

Name: alu_result_sel_pipe

Overview:
Parametrised, registered result selector for the ALU datapath. It generalises the fixed 32-bit 16:1 result mux to WIDTH bits and NUM_IN sources. A one-cycle output register sits behind a valid/ready handshake, backed by a one-entry skid buffer, so the ALU result stage can stall without losing a beat. An out-of-range select is flagged as an error and is never treated as a silent alias.

Parameters:
WIDTH, 32, data width of each source and of the result
NUM_IN, 16, number of selectable sources (legal range 2..16)
SEL_W, 4, select width; must satisfy 2**SEL_W >= NUM_IN

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_bus  input  NUM_IN*WIDTH  packed sources; source k occupies bits [k*WIDTH +: WIDTH]
sel  input  SEL_W  binary source index, sampled with in_valid
in_valid  input  1  upstream beat present
in_ready  output  1  block can accept a beat this cycle
out  output  WIDTH  selected result
out_sel  output  SEL_W  select value that produced out
out_err  output  1  beat was issued with sel >= NUM_IN
out_valid  output  1  out, out_sel and out_err hold a valid beat
out_ready  input  1  downstream accepts the beat

Behaviour:
- One clock, clk. Reset is synchronous and active-low on rst_n. All state changes occur on the rising edge of clk.
- Reset while rst_n = 0 at a clock edge:
  - out_valid = 0, skid_valid = 0, in_ready = 1.
  - out = 0, out_sel = 0, out_err = 0.
  - Any in-flight or skid beat is discarded; reset mid-stall drops both stored beats.
- A beat is accepted when in_valid && in_ready. A beat is delivered when out_valid && out_ready.
- Selection for an accepted beat:
  - If sel < NUM_IN: data = in_bus slice sel, err = 0.
  - If sel >= NUM_IN: data = 0, err = 1.
  - out_sel always echoes the sel value of the beat.
- Latency: a beat accepted at edge N appears on out/out_valid after edge N, provided the output register is empty or drains at edge N.
- Storage is an output register (O) plus a skid register (S).
- in_ready is a registered signal equal to !skid_valid. It has no combinational path from out_ready.
- Per-edge update, given accept (A) and deliver (D):
  - O empty, A: load beat into O; out_valid = 1.
  - O full, D, A, S empty: load beat into O.
  - O full, D, not A, S empty: out_valid = 0.
  - O full, not D, A: load beat into S; skid_valid = 1; in_ready = 0 next cycle.
  - O full, D, S full: move S into O; skid_valid = 0; in_ready = 1 next cycle. A cannot occur in this state because in_ready = 0.
  - O full, not D, S full: hold everything.
- out, out_sel and out_err are stable while out_valid && !out_ready.
- in_bus and sel are don't-care when in_valid = 0. Beats are never reordered, dropped (except on reset) or duplicated.
- Throughput is one beat per cycle when out_ready stays high.
- The combinational select is a case/index over NUM_IN entries. Unused codes up to 2**SEL_W-1 take the error path.

Test Plan:
- Reset, then NUM_IN=16, WIDTH=32, in_bus slice k = 32'hA000_0000+k, sel=5, in_valid=1, out_ready=1 -> next cycle out=32'hA000_0005, out_sel=5, out_valid=1, out_err=0.
- Stream sel=0..15 back-to-back with out_ready=1 -> 16 consecutive beats out=A000_0000..A000_000F, one per cycle, in_ready held at 1.
- Instance with NUM_IN=10, SEL_W=4; send sel=12 -> out=0, out_sel=12, out_err=1. A following sel=9 beat gives out_err=0.
- Hold out_ready=0 and send sel=1 then sel=2 -> O holds slice 1, S takes slice 2, in_ready=0 next cycle. Raise out_ready -> slice 1 then slice 2 delivered in order, in_ready returns to 1.
- Random in_valid/out_ready toggling over 2000 beats -> scoreboard shows no loss, reorder or duplication, and out is stable during every stall.
- Fill O and S, then drive rst_n=0 for one edge -> out_valid=0, in_ready=1, out=0; no stale beat appears afterwards.

Source files
------------

// File: rtl/alu_result_sel_pipe.sv
// Registered WIDTH-bit, NUM_IN:1 result selector with a valid/ready output stage
// and a one-entry skid buffer; out-of-range selects return zero with out_err set.
module alu_result_sel_pipe #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned NUM_IN = 16,
   parameter int unsigned SEL_W  = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_IN*WIDTH-1:0] in_bus,
   input  logic [SEL_W-1:0]        sel,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [WIDTH-1:0]        out,
   output logic [SEL_W-1:0]        out_sel,
   output logic                    out_err,
   output logic                    out_valid,
   input  logic                    out_ready
);

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [SEL_W-1:0] sel;
      logic             err;
   } beat_t;

   beat_t new_beat;
   beat_t o_q, o_d;
   beat_t s_q, s_d;
   logic  o_valid_q, o_valid_d;
   logic  s_valid_q, s_valid_d;
   logic  in_ready_q, in_ready_d;
   logic  accept, deliver;

   // Source select; any code with no matching source takes the error path.
   always_comb begin
      new_beat.data = '0;
      new_beat.sel  = sel;
      new_beat.err  = 1'b1;
      for (int unsigned k = 0; k < NUM_IN; k++) begin
         if (sel == SEL_W'(k)) begin
            new_beat.data = in_bus[k*WIDTH +: WIDTH];
            new_beat.err  = 1'b0;
         end
      end
   end

   assign accept  = in_valid && in_ready_q;
   assign deliver = o_valid_q && out_ready;

   // Next-state for the output register and skid buffer.
   always_comb begin
      o_d       = o_q;
      s_d       = s_q;
      o_valid_d = o_valid_q;
      s_valid_d = s_valid_q;
      if (!o_valid_q) begin
         if (accept) begin
            o_d       = new_beat;
            o_valid_d = 1'b1;
         end
      end else if (s_valid_q) begin
         if (deliver) begin
            o_d       = s_q;
            s_valid_d = 1'b0;
         end
      end else if (deliver) begin
         if (accept) begin
            o_d = new_beat;
         end else begin
            o_valid_d = 1'b0;
         end
      end else if (accept) begin
         s_d       = new_beat;
         s_valid_d = 1'b1;
      end
      in_ready_d = !s_valid_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         o_q        <= '0;
         s_q        <= '0;
         o_valid_q  <= 1'b0;
         s_valid_q  <= 1'b0;
         in_ready_q <= 1'b1;
      end else begin
         o_q        <= o_d;
         s_q        <= s_d;
         o_valid_q  <= o_valid_d;
         s_valid_q  <= s_valid_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign out       = o_q.data;
   assign out_sel   = o_q.sel;
   assign out_err   = o_q.err;
   assign out_valid = o_valid_q;
   assign in_ready  = in_ready_q;

endmodule

// File: tb/tb_alu_result_sel_pipe.sv
// Bench for alu_result_sel_pipe: directed scenarios on a 16-source and a 10-source
// instance plus a randomized handshake run against a queue-based reference model.
module tb_alu_result_sel_pipe;

   localparam int unsigned W    = 32;
   localparam int unsigned NA   = 16;
   localparam int unsigned NB   = 10;
   localparam int unsigned SW   = 4;

   logic            clk = 1'b0;
   logic            rst_n;

   logic [NA*W-1:0] bus_a;
   logic [SW-1:0]   sel_a;
   logic            iv_a, ir_a, ov_a, or_a, err_a;
   logic [W-1:0]    out_a;
   logic [SW-1:0]   osel_a;

   logic [NB*W-1:0] bus_b;
   logic [SW-1:0]   sel_b;
   logic            iv_b, ir_b, ov_b, or_b, err_b;
   logic [W-1:0]    out_b;
   logic [SW-1:0]   osel_b;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [W-1:0]  data;
      logic [SW-1:0] sel;
      logic          err;
   } beat_t;

   always #5 clk = ~clk;

   alu_result_sel_pipe #(.WIDTH(W), .NUM_IN(NA), .SEL_W(SW)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_bus(bus_a), .sel(sel_a), .in_valid(iv_a),
      .in_ready(ir_a), .out(out_a), .out_sel(osel_a), .out_err(err_a),
      .out_valid(ov_a), .out_ready(or_a));

   alu_result_sel_pipe #(.WIDTH(W), .NUM_IN(NB), .SEL_W(SW)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_bus(bus_b), .sel(sel_b), .in_valid(iv_b),
      .in_ready(ir_b), .out(out_b), .out_sel(osel_b), .out_err(err_b),
      .out_valid(ov_b), .out_ready(or_b));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      iv_a = 1'b0; or_a = 1'b1; sel_a = '0; bus_a = '0;
      iv_b = 1'b0; or_b = 1'b1; sel_b = '0; bus_b = '0;
      step(); step();
      checks++;
      if (ov_a !== 1'b0 || ir_a !== 1'b1 || out_a !== '0 || osel_a !== '0 || err_a !== 1'b0) begin
         errors++;
         $display("FAIL reset_a: valid=%b ready=%b out=%h sel=%0d err=%b, want 0 1 0 0 0",
                  ov_a, ir_a, out_a, osel_a, err_a);
      end
      checks++;
      if (ov_b !== 1'b0 || ir_b !== 1'b1 || out_b !== '0 || osel_b !== '0 || err_b !== 1'b0) begin
         errors++;
         $display("FAIL reset_b: valid=%b ready=%b out=%h sel=%0d err=%b, want 0 1 0 0 0",
                  ov_b, ir_b, out_b, osel_b, err_b);
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_basic();
      for (int k = 0; k < int'(NA); k++) bus_a[k*W +: W] = 32'hA000_0000 + 32'(k);
      sel_a = 4'd5; iv_a = 1'b1; or_a = 1'b1;
      step();
      iv_a = 1'b0;
      checks++;
      if (out_a !== 32'hA000_0005 || osel_a !== 4'd5 || ov_a !== 1'b1 || err_a !== 1'b0) begin
         errors++;
         $display("FAIL basic_sel5: out=%h sel=%0d valid=%b err=%b, want a0000005 5 1 0",
                  out_a, osel_a, ov_a, err_a);
      end
      step();
      checks++;
      if (ov_a !== 1'b0) begin
         errors++;
         $display("FAIL basic_drain: valid=%b, want 0", ov_a);
      end
   endtask

   task automatic test_back_to_back();
      or_a = 1'b1;
      for (int s = 0; s < 16; s++) begin
         sel_a = 4'(s); iv_a = 1'b1;
         checks++;
         if (ir_a !== 1'b1) begin
            errors++;
            $display("FAIL stream_ready[%0d]: in_ready=%b, want 1", s, ir_a);
         end
         step();
         checks++;
         if (out_a !== 32'hA000_0000 + 32'(s) || ov_a !== 1'b1 || osel_a !== 4'(s)) begin
            errors++;
            $display("FAIL stream_beat[%0d]: out=%h valid=%b sel=%0d, want %h 1 %0d",
                     s, out_a, ov_a, osel_a, 32'hA000_0000 + 32'(s), s);
         end
      end
      iv_a = 1'b0;
      step();
   endtask

   task automatic test_err();
      for (int k = 0; k < int'(NB); k++) bus_b[k*W +: W] = 32'hB000_0000 + 32'(k);
      or_b = 1'b1; sel_b = 4'd12; iv_b = 1'b1;
      step();
      checks++;
      if (out_b !== '0 || osel_b !== 4'd12 || err_b !== 1'b1 || ov_b !== 1'b1) begin
         errors++;
         $display("FAIL err_sel12: out=%h sel=%0d err=%b valid=%b, want 0 12 1 1",
                  out_b, osel_b, err_b, ov_b);
      end
      sel_b = 4'd9;
      step();
      iv_b = 1'b0;
      checks++;
      if (out_b !== 32'hB000_0009 || osel_b !== 4'd9 || err_b !== 1'b0) begin
         errors++;
         $display("FAIL err_sel9: out=%h sel=%0d err=%b, want b0000009 9 0",
                  out_b, osel_b, err_b);
      end
      sel_b = 4'd15; iv_b = 1'b1;
      step();
      iv_b = 1'b0;
      checks++;
      if (out_b !== '0 || err_b !== 1'b1) begin
         errors++;
         $display("FAIL err_sel15: out=%h err=%b, want 0 1", out_b, err_b);
      end
      step();
   endtask

   task automatic test_stall();
      or_a = 1'b0; sel_a = 4'd1; iv_a = 1'b1;
      step();
      sel_a = 4'd2;
      checks++;
      if (ir_a !== 1'b1 || out_a !== 32'hA000_0001 || ov_a !== 1'b1) begin
         errors++;
         $display("FAIL stall_first: ready=%b out=%h valid=%b, want 1 a0000001 1", ir_a, out_a, ov_a);
      end
      step();
      iv_a = 1'b0;
      checks++;
      if (ir_a !== 1'b0 || out_a !== 32'hA000_0001) begin
         errors++;
         $display("FAIL stall_skid: ready=%b out=%h, want 0 a0000001", ir_a, out_a);
      end
      step();
      checks++;
      if (ir_a !== 1'b0 || out_a !== 32'hA000_0001 || osel_a !== 4'd1 || ov_a !== 1'b1) begin
         errors++;
         $display("FAIL stall_hold: ready=%b out=%h sel=%0d valid=%b, want 0 a0000001 1 1",
                  ir_a, out_a, osel_a, ov_a);
      end
      or_a = 1'b1;
      step();
      checks++;
      if (out_a !== 32'hA000_0002 || ov_a !== 1'b1 || ir_a !== 1'b1) begin
         errors++;
         $display("FAIL stall_release: out=%h valid=%b ready=%b, want a0000002 1 1", out_a, ov_a, ir_a);
      end
      step();
      checks++;
      if (ov_a !== 1'b0 || ir_a !== 1'b1) begin
         errors++;
         $display("FAIL stall_empty: valid=%b ready=%b, want 0 1", ov_a, ir_a);
      end
   endtask

   // Reference: a FIFO of up to two held beats; in_ready means fewer than two held.
   task automatic test_random();
      beat_t sb[$];
      beat_t exp, prev;
      int    accepted = 0;
      int    cycles   = 0;
      bit    stalled  = 1'b0;
      bit    acc, del;
      while ((accepted < 2000 || sb.size() != 0) && cycles < 20000) begin
         for (int k = 0; k < int'(NB); k++) bus_b[k*W +: W] = $urandom;
         sel_b = 4'($urandom_range(0, 15));
         iv_b  = (accepted < 2000) && ($urandom_range(0, 99) < 65);
         or_b  = (accepted >= 2000) || ($urandom_range(0, 99) < 60);
         checks++;
         if (ov_b !== (sb.size() > 0) || ir_b !== (sb.size() < 2)) begin
            errors++;
            $display("FAIL rand_occupancy@%0d: valid=%b ready=%b, want %b %b",
                     cycles, ov_b, ir_b, sb.size() > 0, sb.size() < 2);
         end
         if (stalled) begin
            checks++;
            if ({out_b, osel_b, err_b} !== prev) begin
               errors++;
               $display("FAIL rand_stable@%0d: got %h, want %h", cycles, {out_b, osel_b, err_b}, prev);
            end
         end
         acc = iv_b && (sb.size() < 2);
         del = ov_b && or_b;
         if (del && sb.size() > 0) begin
            exp = sb.pop_front();
            checks++;
            if (out_b !== exp.data || osel_b !== exp.sel || err_b !== exp.err) begin
               errors++;
               $display("FAIL rand_beat@%0d: out=%h sel=%0d err=%b, want %h %0d %b",
                        cycles, out_b, osel_b, err_b, exp.data, exp.sel, exp.err);
            end
         end
         if (acc) begin
            exp.sel  = sel_b;
            exp.err  = (int'(sel_b) >= int'(NB));
            exp.data = exp.err ? '0 : bus_b[int'(sel_b)*W +: W];
            sb.push_back(exp);
            accepted++;
         end
         stalled = ov_b && !or_b;
         prev    = {out_b, osel_b, err_b};
         step();
         cycles++;
      end
      iv_b = 1'b0; or_b = 1'b1;
      checks++;
      if (cycles >= 20000) begin
         errors++;
         $display("FAIL rand_timeout: accepted=%0d pending=%0d, want 2000 0", accepted, sb.size());
      end
      step();
   endtask

   task automatic test_reset_mid();
      or_a = 1'b0; iv_a = 1'b1; sel_a = 4'd3;
      step();
      sel_a = 4'd4;
      step();
      iv_a = 1'b0;
      checks++;
      if (ir_a !== 1'b0 || ov_a !== 1'b1) begin
         errors++;
         $display("FAIL midrst_full: ready=%b valid=%b, want 0 1", ir_a, ov_a);
      end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      checks++;
      if (ov_a !== 1'b0 || ir_a !== 1'b1 || out_a !== '0 || osel_a !== '0 || err_a !== 1'b0) begin
         errors++;
         $display("FAIL midrst_clear: valid=%b ready=%b out=%h sel=%0d err=%b, want 0 1 0 0 0",
                  ov_a, ir_a, out_a, osel_a, err_a);
      end
      or_a = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (ov_a !== 1'b0 || out_a !== '0) begin
            errors++;
            $display("FAIL midrst_stale[%0d]: valid=%b out=%h, want 0 0", i, ov_a, out_a);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_err();
      test_stall();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
